// File: rtl/usage_pkg.sv
// Purpose : shared types and constants for the usage profiler slice.
// Contents: sample width DW, default window depth, usage_t (one DW-bit
//           usage value), sample_t (talk/data pair), prof_state_t (FILL/RUN).
package usage_pkg;

  localparam int DW               = 6;
  localparam int WIN_LOG2_DEFAULT = 3;

  typedef logic [DW-1:0] usage_t;

  typedef struct packed {
    usage_t talk;
    usage_t data;
  } sample_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } prof_state_t;

endpackage

// File: rtl/usage_profiler_if.sv
// Purpose : sample-in / averages-out bus of the usage profiler.
// Signals : s_valid/s_ready/s_talk/s_data  - incoming usage samples
//           avg_valid/avg_ready/avgtalk/avgdata - floor-averaged window output
//           win_full - window has been filled since last reset/flush
// Handshake: a transfer happens on a rising edge where valid & ready are both
//           high; valid never waits on ready, and once valid is raised the
//           payload is held stable until the transfer edge.
// Modports: master = sample producer / average consumer, slave = profiler.
interface usage_profiler_if;
  import usage_pkg::*;

  logic   s_valid;
  logic   s_ready;
  usage_t s_talk;
  usage_t s_data;
  logic   avg_valid;
  logic   avg_ready;
  usage_t avgtalk;
  usage_t avgdata;
  logic   win_full;

  modport master (
    output s_valid, s_talk, s_data, avg_ready,
    input  s_ready, avg_valid, avgtalk, avgdata, win_full
  );

  modport slave (
    input  s_valid, s_talk, s_data, avg_ready,
    output s_ready, avg_valid, avgtalk, avgdata, win_full
  );
endinterface

// File: rtl/usage_ring.sv
// Purpose : 2^WIN_LOG2-deep ring of sample_t with a write pointer.
//           o_old is the slot the next write will overwrite, i.e. the oldest
//           sample in the window once the ring has been filled.
// Ports   : clk, rst (sync, active-high), i_clr (sync clear, same as rst),
//           i_we (write strobe), i_wdata (sample to store), o_old (oldest slot).
module usage_ring
  import usage_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_clr,
  input  logic    i_we,
  input  sample_t i_wdata,
  output sample_t o_old
);

  localparam int DEPTH = 1 << WIN_LOG2;

  sample_t             r_ring [DEPTH];
  logic [WIN_LOG2-1:0] r_wptr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_ring[i] <= '0;
      r_wptr <= '0;
    end else if (i_we) begin
      r_ring[r_wptr] <= i_wdata;
      r_wptr         <= r_wptr + 1'b1;
    end
  end

  assign o_old = r_ring[r_wptr];

endmodule

// File: rtl/usage_profiler.sv
// Purpose : sliding-window averager of talk/data usage samples feeding the
//           subscription-plan checker. Keeps running sums over the last
//           2^WIN_LOG2 samples and publishes floor averages through a
//           one-entry output register.
// Ports   : clk, rst (sync, active-high), flush (sync clear, same as rst),
//           bus (usage_profiler_if.slave), o_state (debug: FSM state).
module usage_profiler
  import usage_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  usage_profiler_if.slave        bus,
  output prof_state_t            o_state
);

  localparam int SW    = DW + WIN_LOG2;
  localparam int DEPTH = 1 << WIN_LOG2;

  logic              w_clr;
  logic              w_accept;
  logic              w_fill_last;
  logic              w_out;
  sample_t           w_new;
  sample_t           w_old;
  logic [SW-1:0]     w_talk_sum_next;
  logic [SW-1:0]     w_data_sum_next;

  prof_state_t       r_state;
  logic [WIN_LOG2:0] r_fill_cnt;
  logic [SW-1:0]     r_talk_sum;
  logic [SW-1:0]     r_data_sum;
  logic              r_avg_valid;
  usage_t            r_avgtalk;
  usage_t            r_avgdata;
  logic              r_win_full;

  assign w_clr    = rst | flush;
  // A held, unconsumed result blocks new samples so nothing is lost.
  assign bus.s_ready = ~w_clr & (~r_avg_valid | bus.avg_ready);
  assign w_accept    = bus.s_valid & bus.s_ready;

  assign w_new = '{talk: bus.s_talk, data: bus.s_data};

  usage_ring #(.WIN_LOG2(WIN_LOG2)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_we    (w_accept),
    .i_wdata (w_new),
    .o_old   (w_old)
  );

  // sum + new can briefly exceed SW bits, but subtracting the oldest sample
  // (always <= sum) brings the modular result back to the exact value.
  assign w_talk_sum_next = r_talk_sum + SW'(bus.s_talk) - SW'(w_old.talk);
  assign w_data_sum_next = r_data_sum + SW'(bus.s_data) - SW'(w_old.data);

  assign w_fill_last = (r_state == FILL) &&
                       (r_fill_cnt == (WIN_LOG2+1)'(DEPTH - 1));
  assign w_out       = w_accept & ((r_state == RUN) | w_fill_last);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_win_full <= 1'b0;
      r_talk_sum <= '0;
      r_data_sum <= '0;
    end else if (w_accept) begin
      r_talk_sum <= w_talk_sum_next;
      r_data_sum <= w_data_sum_next;
      if (r_state == FILL) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        if (w_fill_last) begin
          r_state    <= RUN;
          r_win_full <= 1'b1;
        end
      end
    end
  end

  // Output register: reload on a new result, otherwise drop valid once taken.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_avg_valid <= 1'b0;
      r_avgtalk   <= '0;
      r_avgdata   <= '0;
    end else if (w_out) begin
      r_avg_valid <= 1'b1;
      r_avgtalk   <= w_talk_sum_next[SW-1:WIN_LOG2];
      r_avgdata   <= w_data_sum_next[SW-1:WIN_LOG2];
    end else if (bus.avg_ready) begin
      r_avg_valid <= 1'b0;
    end
  end

  assign bus.avg_valid = r_avg_valid;
  assign bus.avgtalk   = r_avgtalk;
  assign bus.avgdata   = r_avgdata;
  assign bus.win_full  = r_win_full;
  assign o_state       = r_state;

endmodule

// File: tb/tb_usage_profiler.sv
module tb_usage_profiler;
  import usage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  usage_profiler_if bus ();
  prof_state_t      o_state;

  usage_profiler #(.WIN_LOG2(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .o_state (o_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0] talk;
    logic [5:0] data;
    logic       exp_out;
    logic [5:0] exp_t;
    logic [5:0] exp_d;
    logic       exp_wf;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input int t, input int d, input int o,
                              input int et, input int ed, input int wf);
    vec_t v;
    v.talk = 6'(t); v.data = 6'(d); v.exp_out = 1'(o);
    v.exp_t = 6'(et); v.exp_d = 6'(ed); v.exp_wf = 1'(wf);
    return v;
  endfunction

  // ---------------- scoreboard model ----------------
  logic [2*DW-1:0] exp_q[$];
  int   m_rt [8];
  int   m_rd [8];
  int   m_wp = 0, m_cnt = 0, m_ts = 0, m_ds = 0;
  logic m_av = 1'b0, m_wf = 1'b0;

  task automatic sb_step();
    logic clr, sready, acc, out;
    logic [2*DW-1:0] e;
    clr    = rst | flush;
    sready = !clr && (!m_av || bus.avg_ready);
    chk("sb_s_ready", bus.s_ready, sready);
    chk("sb_avg_valid", bus.avg_valid, m_av);
    chk("sb_win_full", bus.win_full, m_wf);
    if (!clr && m_av && bus.avg_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra_output: got talk=%0d data=%0d expected none",
                 bus.avgtalk, bus.avgdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_avgtalk", bus.avgtalk, e[2*DW-1:DW]);
        chk("sb_avgdata", bus.avgdata, e[DW-1:0]);
      end
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) begin m_rt[i] = 0; m_rd[i] = 0; end
      m_wp = 0; m_cnt = 0; m_ts = 0; m_ds = 0; m_av = 0; m_wf = 0;
      exp_q.delete();
    end else begin
      acc = bus.s_valid && sready;
      out = 1'b0;
      if (acc) begin
        m_ts = m_ts - m_rt[m_wp] + bus.s_talk;
        m_ds = m_ds - m_rd[m_wp] + bus.s_data;
        m_rt[m_wp] = bus.s_talk;
        m_rd[m_wp] = bus.s_data;
        m_wp = (m_wp + 1) % 8;
        if (m_wf) out = 1'b1;
        else begin
          m_cnt++;
          if (m_cnt == 8) begin m_wf = 1'b1; out = 1'b1; end
        end
      end
      if (out) begin
        exp_q.push_back({6'(m_ts / 8), 6'(m_ds / 8)});
        m_av = 1'b1;
      end else if (bus.avg_ready) begin
        m_av = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic apply_vec(input int i);
    bus.s_valid = 1'b1;
    bus.s_talk  = tbl[i].talk;
    bus.s_data  = tbl[i].data;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("vec_avg_valid", bus.avg_valid, tbl[i].exp_out);
    chk("vec_win_full", bus.win_full, tbl[i].exp_wf);
    if (tbl[i].exp_out) begin
      chk("vec_avgtalk", bus.avgtalk, tbl[i].exp_t);
      chk("vec_avgdata", bus.avgdata, tbl[i].exp_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int t, input int d);
    bus.s_valid = 1'b1;
    bus.s_talk  = 6'(t);
    bus.s_data  = 6'(d);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.s_valid = 1'b0; bus.s_talk = '0; bus.s_data = '0; bus.avg_ready = 1'b1;

    for (int i = 0; i < 7; i++) tbl[i] = mk(10, 20, 0, 0, 0, 0);
    tbl[7]  = mk(10, 20, 1, 10, 20, 1);
    tbl[8]  = mk(18, 28, 1, 11, 21, 1);
    tbl[9]  = mk(63, 63, 1, 17, 26, 1);
    tbl[10] = mk(63, 63, 1, 24, 31, 1);
    tbl[11] = mk(63, 63, 1, 30, 37, 1);
    tbl[12] = mk(63, 63, 1, 37, 42, 1);
    tbl[13] = mk(63, 63, 1, 44, 47, 1);
    tbl[14] = mk(63, 63, 1, 50, 53, 1);
    tbl[15] = mk(63, 63, 1, 57, 58, 1);
    tbl[16] = mk(63, 63, 1, 63, 63, 1);
    for (int i = 17; i < 24; i++) tbl[i] = mk(7, 3, 0, 0, 0, 0);
    tbl[24] = mk(7, 3, 1, 7, 3, 1);

    fork
      forever begin
        @(negedge clk);
        sb_step();
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_avg_valid", bus.avg_valid, 0);
    chk("rst_avgtalk", bus.avgtalk, 0);
    chk("rst_avgdata", bus.avgdata, 0);
    chk("rst_win_full", bus.win_full, 0);
    chk("rst_state", int'(o_state), int'(FILL));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", bus.s_ready, 1);
    @(posedge clk); #1;

    // fill, first step, saturate with 63s
    for (int i = 0; i <= 16; i++) apply_vec(i);
    chk("run_state", int'(o_state), int'(RUN));

    // backpressure: 30/40 gives 471/481 -> 58/60; held 5/5 then gives 51/52
    bus.avg_ready = 1'b0;
    send(30, 40);
    bus.s_talk = 6'd5; bus.s_data = 6'd5;
    repeat (10) begin
      @(negedge clk);
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_avg_valid", bus.avg_valid, 1);
      chk("bp_avgtalk", bus.avgtalk, 58);
      chk("bp_avgdata", bus.avgdata, 60);
      @(posedge clk); #1;
    end
    bus.avg_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_s_ready", bus.s_ready, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", bus.avg_valid, 1);
    chk("bp_next_avgtalk", bus.avgtalk, 51);
    chk("bp_next_avgdata", bus.avgdata, 52);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_valid", bus.avg_valid, 0);
    chk("hold_avgtalk", bus.avgtalk, 51);
    chk("hold_avgdata", bus.avgdata, 52);
    @(posedge clk); #1;

    // streaming ramp, checked by the scoreboard every cycle
    for (int i = 0; i < 64; i++) send(i, 63 - i);
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // flush mid-FILL with a sample offered on the flush cycle
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 5; k++) send(50, 60);
    flush = 1'b1;
    bus.s_talk = 6'd1; bus.s_data = 6'd1;
    @(negedge clk);
    chk("flush_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("flush_win_full", bus.win_full, 0);
    chk("flush_avg_valid", bus.avg_valid, 0);
    chk("flush_state", int'(o_state), int'(FILL));
    @(posedge clk); #1;
    for (int i = 17; i < 24; i++) apply_vec(i);

    // last fill sample, then rst together with a pending handshake
    bus.s_valid = 1'b1;
    bus.s_talk  = tbl[24].talk;
    bus.s_data  = tbl[24].data;
    @(posedge clk); #1;
    bus.s_valid   = 1'b0;
    bus.avg_ready = 1'b1;
    rst           = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", bus.avg_valid, tbl[24].exp_out);
    chk("pre_rst_avgtalk", bus.avgtalk, tbl[24].exp_t);
    chk("pre_rst_avgdata", bus.avgdata, tbl[24].exp_d);
    chk("pre_rst_win_full", bus.win_full, tbl[24].exp_wf);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.avg_valid, 0);
    chk("post_rst_avgtalk", bus.avgtalk, 0);
    chk("post_rst_avgdata", bus.avgdata, 0);
    chk("post_rst_win_full", bus.win_full, 0);
    chk("post_rst_state", int'(o_state), int'(FILL));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
